ps2_rx: RTL

Receives PS/2 keyboard frames from the ps2_clk/ps2_data pins, validates them and queues scan-code bytes in a small FIFO. It sits directly upstream of the keyboard decode FSM. It presents the head byte on data with a ready/nextdata_n handshake that the FSM consumes.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_rx_if.sv | 20 ++
 rtl/ps2_byte_fifo.sv | 52 +++++
 rtl/ps2_rx.sv | 106 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM encoding, frame constants and
// the frame validity check used by the receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_state_t;

   localparam int         PS2_FRAME_BITS = 11;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;

   // Odd parity over data+parity, and the stop bit must be high.
   function automatic logic ps2_frame_ok(input logic [7:0] d, input logic p,
                                         input logic stop);
      return stop & (^{d, p});
   endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// PS/2 pins plus the byte handshake toward the keyboard decode FSM.
interface ps2_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport slave (
      input  ps2_clk, ps2_data, nextdata_n,
      output data, ready, overflow, frame_err
   );

   modport master (
      output ps2_clk, ps2_data, nextdata_n,
      input  data, ready, overflow, frame_err
   );
endinterface

// File: rtl/ps2_byte_fifo.sv
// Scan-code byte FIFO: head byte shown combinationally, sticky overflow
// when a byte arrives while full and nothing is being popped.
module ps2_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop_req,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, wr_en;

   assign ready = (count != '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign pop   = pop_req & ready;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign wr_en = push & (~full | pop);
   assign data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: pin synchroniser, frame FSM with inactivity
// timeout, and a byte FIFO feeding the decode FSM.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic     clk,
   input  logic     rst,
   ps2_rx_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2, clk_s3;
   logic          dat_s1, dat_s2;
   logic          fall;
   ps2_state_t    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par;
   logic [TW-1:0] timer;
   logic          frame_err_q;
   logic          push;

   // Synchronisers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= bus.ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= bus.ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;
   // Push straight from the stop-bit edge so the byte lands on that same edge.
   assign push = (state == ST_STOP) & fall & ps2_frame_ok(shift, par, dat_s2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         par         <= 1'b0;
         timer       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (state == ST_IDLE) begin
            timer <= '0;
            if (fall && !dat_s2) begin
               state   <= ST_DATA;
               bit_cnt <= '0;
            end
         end else if (fall) begin
            timer <= '0;
            case (state)
               ST_DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par   <= dat_s2;
                  state <= ST_STOP;
               end
               ST_STOP: begin
                  frame_err_q <= ~ps2_frame_ok(shift, par, dat_s2);
                  state       <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_IDLE;
            frame_err_q <= 1'b1;
            timer       <= '0;
            shift       <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   assign bus.frame_err = frame_err_q;

   ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift),
      .pop_req   (~bus.nextdata_n),
      .data      (bus.data),
      .ready     (bus.ready),
      .overflow  (bus.overflow)
   );

endmodule
